// File: rtl/mure_pkg.sv
// mure_pkg: shared constants and helpers for the multiple-retirement serializer.
//   MURE_FIFO_DEPTH : default ingress FIFO depth, shared with the serializer datapath
//   sel_len()       : width of a port-select index, never narrower than 1 bit
package mure_pkg;

   localparam int unsigned MURE_FIFO_DEPTH = 16;

   // Index width for n ports; a single port still needs a 1-bit select.
   function automatic int unsigned sel_len(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mure_lzc_onehot.sv
// mure_lzc_onehot: lowest-set-bit finder.
//   in_i     : input vector
//   idx_o    : index of the lowest set bit (0 when in_i is zero)
//   empty_o  : no bit set
//   single_o : exactly one bit set
module mure_lzc_onehot
   import mure_pkg::*;
#(
   parameter  int unsigned Width = 2,
   localparam int unsigned IdxW  = sel_len(Width)
) (
   input  logic [Width-1:0] in_i,
   output logic [IdxW-1:0]  idx_o,
   output logic             empty_o,
   output logic             single_o
);

   // Scan high to low so the lowest set bit wins.
   always_comb begin
      idx_o = '0;
      for (int i = Width - 1; i >= 0; i--) begin
         if (in_i[i]) idx_o = IdxW'(i);
      end
   end

   assign empty_o  = (in_i == '0);
   // Clearing the lowest set bit leaves zero only for a one-hot vector.
   assign single_o = !empty_o && ((in_i & (in_i - Width'(1))) == '0);

endmodule

// File: rtl/mure_sequencer.sv
// mure_sequencer: picks which commit port's head entry drives the single
// retirement output each cycle, pops all ingress FIFOs after the last beat,
// and raises a registered stall request when the FIFOs near full.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   bundle_valid_i  : head bundle present
//   retire_mask_i   : per-port retire flags of the head bundle
//   exc_i           : head bundle carries exception/interrupt info
//   usage_i, full_i : port-0 FIFO fill level and full flag
//   flush_i         : discard in-progress bundle state
//   out_ready_i     : encoder accepts a beat
//   out_valid_o, sel_o, last_o : combinational beat handshake and port select
//   pop_o           : combinational pop of all ingress FIFOs
//   stall_o         : registered back-pressure request to the CPU
module mure_sequencer
   import mure_pkg::*;
#(
   parameter  int unsigned NrRetiredInstr = 2,
   parameter  int unsigned FifoDepth      = MURE_FIFO_DEPTH,
   parameter  int unsigned StallThresh    = 2,
   localparam int unsigned SelW           = sel_len(NrRetiredInstr),
   localparam int unsigned UsageW         = $clog2(FifoDepth)
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      bundle_valid_i,
   input  logic [NrRetiredInstr-1:0] retire_mask_i,
   input  logic                      exc_i,
   input  logic [UsageW-1:0]         usage_i,
   input  logic                      full_i,
   input  logic                      flush_i,
   input  logic                      out_ready_i,
   output logic                      out_valid_o,
   output logic [SelW-1:0]           sel_o,
   output logic                      last_o,
   output logic                      pop_o,
   output logic                      stall_o
);

   // One bit wider than usage so FifoDepth itself is representable.
   localparam int unsigned FreeW = UsageW + 1;

   logic [NrRetiredInstr-1:0] served_q, served_d;
   logic [NrRetiredInstr-1:0] remaining;
   logic [SelW-1:0]           rem_idx;
   logic                      rem_empty;
   logic                      rem_single;
   logic                      stall_q, stall_d;
   logic [FreeW-1:0]          free_c;

   assign remaining = retire_mask_i & ~served_q;

   mure_lzc_onehot #(
      .Width (NrRetiredInstr)
   ) u_lzc (
      .in_i     (remaining),
      .idx_o    (rem_idx),
      .empty_o  (rem_empty),
      .single_o (rem_single)
   );

   // Beat selection, handshake and served-mask update.
   always_comb begin
      out_valid_o = 1'b0;
      sel_o       = '0;
      last_o      = 1'b0;
      pop_o       = 1'b0;
      served_d    = served_q;
      if (flush_i) begin
         served_d = '0;
      end else if (bundle_valid_i) begin
         if (retire_mask_i == '0) begin
            // Nothing retired: a trap-only bundle still needs one beat,
            // otherwise drop it without a beat.
            served_d = '0;
            if (exc_i) begin
               out_valid_o = 1'b1;
               last_o      = 1'b1;
               pop_o       = out_ready_i;
            end else begin
               pop_o = 1'b1;
            end
         end else if (!rem_empty) begin
            out_valid_o = 1'b1;
            sel_o       = rem_idx;
            last_o      = rem_single;
            if (out_ready_i) begin
               if (rem_single) begin
                  pop_o    = 1'b1;
                  served_d = '0;
               end else begin
                  served_d = served_q | (NrRetiredInstr'(1) << rem_idx);
               end
            end
         end
      end
   end

   // usage wraps to 0 when full, so full takes priority.
   assign free_c  = FreeW'(FifoDepth) - FreeW'(usage_i);
   assign stall_d = full_i | (free_c <= FreeW'(StallThresh));

   // State registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         served_q <= '0;
         stall_q  <= 1'b0;
      end else begin
         served_q <= served_d;
         stall_q  <= stall_d;
      end
   end

   assign stall_o = stall_q;

endmodule

// File: tb/tb_mure_sequencer.sv
// tb_mure_sequencer: scoreboard bench for mure_sequencer (2 ports, depth 16,
// threshold 2). Bundles queued by the bench act as the FIFO head; the
// expected beats of every queued bundle sit in a scoreboard queue and are
// popped as the DUT fires them.
module tb_mure_sequencer;

   typedef struct packed {
      logic [1:0] mask;
      logic       exc;
   } bundle_t;

   typedef struct packed {
      logic [0:0] sel;
      logic       last;
   } beat_t;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       bundle_valid_i;
   logic [1:0] retire_mask_i;
   logic       exc_i;
   logic [3:0] usage_i;
   logic       full_i;
   logic       flush_i;
   logic       out_ready_i;
   logic       out_valid_o;
   logic [0:0] sel_o;
   logic       last_o;
   logic       pop_o;
   logic       stall_o;

   int n_checks = 0;
   int n_fail   = 0;
   int pop_cnt  = 0;
   logic stall_exp = 1'b0;

   bundle_t bq[$];
   beat_t   sbq[$];

   always #5 clk_i = ~clk_i;

   mure_sequencer #(
      .NrRetiredInstr (2),
      .FifoDepth      (16),
      .StallThresh    (2)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .bundle_valid_i (bundle_valid_i),
      .retire_mask_i  (retire_mask_i),
      .exc_i          (exc_i),
      .usage_i        (usage_i),
      .full_i         (full_i),
      .flush_i        (flush_i),
      .out_ready_i    (out_ready_i),
      .out_valid_o    (out_valid_o),
      .sel_o          (sel_o),
      .last_o         (last_o),
      .pop_o          (pop_o),
      .stall_o        (stall_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected beats of one bundle: lowest port first, final one marked last.
   task automatic push_beats(input bundle_t b);
      beat_t e;
      if (b.mask == 2'b00) begin
         if (b.exc) begin
            e.sel = 1'b0; e.last = 1'b1; sbq.push_back(e);
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (b.mask[i]) begin
               e.sel  = 1'(i);
               e.last = (i == 1) || (b.mask[1] == 1'b0);
               sbq.push_back(e);
            end
         end
      end
   endtask

   task automatic push_bundle(input logic [1:0] mask, input logic exc);
      bundle_t b;
      b.mask = mask; b.exc = exc;
      bq.push_back(b);
      push_beats(b);
   endtask

   // Served state was discarded: every queued bundle is emitted in full again.
   task automatic rebuild();
      sbq.delete();
      foreach (bq[i]) push_beats(bq[i]);
   endtask

   task automatic apply_head();
      if (bq.size() != 0) begin
         bundle_valid_i = 1'b1;
         retire_mask_i  = bq[0].mask;
         exc_i          = bq[0].exc;
      end else begin
         bundle_valid_i = 1'b0;
         retire_mask_i  = 2'b00;
         exc_i          = 1'b0;
      end
   endtask

   // One clock: check outputs at the falling edge, advance the head after the rising edge.
   task automatic cycle();
      logic popped, fl, st_nxt, active;
      beat_t e;
      @(negedge clk_i);
      check("stall", 32'(stall_o), 32'(stall_exp));
      active = (bq.size() != 0) && !flush_i && ((bq[0].mask != 2'b00) || bq[0].exc);
      if (flush_i) begin
         check("flush_valid", 32'(out_valid_o), 32'd0);
         check("flush_pop", 32'(pop_o), 32'd0);
      end else begin
         check("valid", 32'(out_valid_o), 32'(active));
         if (out_valid_o && sbq.size() == 0) begin
            check("unexpected_beat", 32'(out_valid_o), 32'd0);
         end else if (out_valid_o) begin
            e = sbq[0];
            check("sel", 32'(sel_o), 32'(e.sel));
            check("last", 32'(last_o), 32'(e.last));
            if (out_ready_i) begin
               void'(sbq.pop_front());
               check("pop_fire", 32'(pop_o), 32'(e.last));
            end else begin
               check("pop_hold", 32'(pop_o), 32'd0);
            end
         end else begin
            check("pop_idle", 32'(pop_o),
                  32'((bq.size() != 0) && bq[0].mask == 2'b00 && !bq[0].exc));
         end
      end
      popped = pop_o;
      fl     = flush_i;
      st_nxt = full_i | ((5'd16 - 5'(usage_i)) <= 5'd2);
      if (popped) pop_cnt++;
      @(posedge clk_i);
      #1;
      stall_exp = st_nxt;
      if (popped) begin
         if (bq.size() == 0) check("pop_empty", 32'd1, 32'd0);
         else void'(bq.pop_front());
      end
      if (fl) rebuild();
      apply_head();
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (bq.size() != 0 && n < budget) begin
         cycle();
         n++;
      end
      check("drain_timeout", 32'(bq.size()), 32'd0);
      check("sb_empty", 32'(sbq.size()), 32'd0);
   endtask

   initial begin
      rst_ni = 1'b0;
      bundle_valid_i = 1'b0; retire_mask_i = 2'b00; exc_i = 1'b0;
      usage_i = 4'd0; full_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
      #12;
      check("rst_valid", 32'(out_valid_o), 32'd0);
      check("rst_pop", 32'(pop_o), 32'd0);
      check("rst_stall", 32'(stall_o), 32'd0);
      check("rst_sel", 32'(sel_o), 32'd0);
      rst_ni = 1'b1;
      @(posedge clk_i); #1;
      repeat (2) cycle();

      // Back-to-back bundles with a two-beat then one-beat pattern.
      push_bundle(2'b11, 1'b0);
      push_bundle(2'b01, 1'b0);
      apply_head();
      drain(10);

      // Single upper port, silent empty bundle, trap-only bundle.
      push_bundle(2'b10, 1'b0);
      push_bundle(2'b00, 1'b0);
      push_bundle(2'b00, 1'b1);
      apply_head();
      drain(10);

      // Encoder backpressure for three cycles.
      out_ready_i = 1'b0;
      pop_cnt = 0;
      push_bundle(2'b11, 1'b0);
      apply_head();
      repeat (3) cycle();
      check("hold_beats_left", 32'(sbq.size()), 32'd2);
      out_ready_i = 1'b1;
      drain(10);
      check("hold_pop_count", 32'(pop_cnt), 32'd1);

      // Stall threshold and full priority.
      usage_i = 4'd13; cycle();
      usage_i = 4'd14; cycle();
      cycle();
      check("stall_at_14", 32'(stall_o), 32'd1);
      usage_i = 4'd0; full_i = 1'b1; cycle();
      cycle();
      check("stall_full", 32'(stall_o), 32'd1);
      full_i = 1'b0; usage_i = 4'd10; cycle();
      cycle();
      check("stall_clear", 32'(stall_o), 32'd0);

      // Flush after the first beat of a two-beat bundle.
      push_bundle(2'b11, 1'b0);
      apply_head();
      cycle();
      check("pre_flush_left", 32'(sbq.size()), 32'd1);
      flush_i = 1'b1;
      cycle();
      flush_i = 1'b0;
      check("post_flush_left", 32'(sbq.size()), 32'd2);
      drain(10);

      // Asynchronous reset after the first beat of a two-beat bundle.
      push_bundle(2'b11, 1'b0);
      apply_head();
      cycle();
      rst_ni = 1'b0;
      #2;
      check("arst_sel", 32'(sel_o), 32'd0);
      check("arst_last", 32'(last_o), 32'd0);
      check("arst_stall", 32'(stall_o), 32'd0);
      rst_ni = 1'b1;
      stall_exp = 1'b0;
      rebuild();
      drain(10);

      // Random bundles with random backpressure.
      for (int i = 0; i < 40; i++) begin
         push_bundle(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
      apply_head();
      for (int n = 0; n < 400 && bq.size() != 0; n++) begin
         out_ready_i = ($urandom_range(0, 3) != 0);
         usage_i = 4'($urandom_range(8, 15));
         cycle();
      end
      out_ready_i = 1'b1;
      drain(100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mure_sequencer.md
Name: mure_sequencer

Overview:
- Control block for the multiple-retirement serializer.
- Watches the head bundle of the per-commit-port ingress FIFOs and selects which port's entry drives the single-retirement output to the trace encoder each cycle.
- Skips ports with no retirement and pops all FIFOs once the last beat of a bundle is accepted.
- Applies ready/valid backpressure from the encoder and raises a stall request toward the CPU when the FIFOs near full.

Parameters:
NrRetiredInstr, 2, number of commit ports (>=1)
FifoDepth, 16, depth of each ingress FIFO
StallThresh, 2, free entries at or below which stall_o asserts

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
bundle_valid_i  in  1  head bundle present (FIFOs not empty)
retire_mask_i  in  NrRetiredInstr  bit i = port i of head bundle retires (iretire != 0)
exc_i  in  1  head bundle carries exception/interrupt info (cause valid)
usage_i  in  $clog2(FifoDepth)  fill level of port-0 FIFO
full_i  in  1  port-0 FIFO full
flush_i  in  1  synchronous discard of in-progress bundle state
out_ready_i  in  1  trace encoder accepts beat
out_valid_o  out  1  beat valid on serializer output
sel_o  out  $clog2(NrRetiredInstr) (min 1)  port index to mux out
last_o  out  1  beat is final beat of bundle
pop_o  out  1  pop all ingress FIFOs this cycle
stall_o  out  1  registered back-pressure request to CPU

Behaviour:
- Single state register served_q[NrRetiredInstr-1:0]: ports of the head bundle already emitted. Reset value 0.
- Stall register stall_q. Reset value 0.
- remaining = retire_mask_i & ~served_q. The head bundle is stable until popped.
- Empty bundle: bundle_valid_i=1 and retire_mask_i=0.
  - With exc_i=1: emit one beat, sel_o=0, last_o=1.
  - With exc_i=0: out_valid_o=0, pop_o=1 in the same cycle. The bundle is discarded with no beat.
- Normal case:
  - out_valid_o = bundle_valid_i & (remaining != 0) & ~flush_i.
  - sel_o = index of lowest set bit of remaining. In-order retirement, port 0 oldest.
  - last_o = 1 when remaining has exactly one bit set.
- Handshake:
  - Beat fires when out_valid_o & out_ready_i.
  - On a non-last fire, served_q |= onehot(sel_o) next cycle.
  - On a last fire, pop_o=1 combinationally that cycle and served_q <= 0.
- Zero-bubble throughput: a new bundle's first beat can fire the cycle after a pop. One beat per cycle when out_ready_i=1.
- Stalls: with out_ready_i=0, out_valid_o holds. sel_o and last_o must be stable until the beat fires, since inputs and served_q are unchanged.
- Latency: combinational from head bundle to out_valid_o. pop_o is combinational from out_ready_i.
- stall_q <= full_i | (FifoDepth - usage_i <= StallThresh). stall_o = stall_q, one-cycle latency.
  - usage_i wraps to 0 when full, so full_i takes priority.
- flush_i=1:
  - served_q <= 0 and out_valid_o=0 that cycle.
  - pop_o=0 (the FIFOs are flushed externally).
  - stall_q still updates.
- bundle_valid_i=0: out_valid_o=0, pop_o=0, served_q held.
- Asynchronous reset mid-bundle clears served_q and stall_q immediately. With no bundle present, all outputs read 0.
- NrRetiredInstr=1: served_q is unused. Every beat is last. sel_o=0.

Decomposition:
- mure_pkg gets:
  - SEL_LEN = max(1,$clog2(NrRetiredInstr)) helper function.
  - Default FIFO depth constant MURE_FIFO_DEPTH=16 shared with the serializer.
- Sub-module: mure_lzc_onehot, a lowest-set-bit finder returning index and a "single bit set" flag. It is reusable. Alternatively, common_cells lzc may be instantiated with MODE=0 for the index.

Test Plan:
- Reset, bundle_valid_i=0 -> out_valid_o=0, pop_o=0, stall_o=0, sel_o=0.
- mask=2'b11, out_ready_i=1 constant -> cycle0 sel=0 last=0 pop=0; cycle1 sel=1 last=1 pop=1; next bundle mask=2'b01 cycle2 sel=0 last=1 pop=1.
- mask=2'b10 -> single beat sel=1 last=1 pop=1; mask=2'b00 exc=0 -> pop=1, out_valid=0; mask=2'b00 exc=1 -> beat sel=0 last=1 pop=1.
- mask=2'b11, out_ready_i low 3 cycles then high -> out_valid=1 sel=0 stable 3 cycles, fires cycle 4, sel=1 cycle 5, exactly one pop.
- usage_i 13 -> 14 (FifoDepth=16, StallThresh=2) -> stall_o rises one cycle after 14; full_i=1 usage 0 -> stall_o=1; usage 10 -> stall_o=0 next cycle.
- Mid-bundle (served_q=2'b01) assert flush_i -> out_valid=0, pop=0; next cycle same head mask=2'b11 emits sel=0 again. Async reset mid-bundle gives the same served_q=0 outcome.
